// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared definitions for the HI/LO multiply/divide sequencer.
//   - op encodings driven by the EX stage on the op bus
//   - FSM state encoding used by muldiv_seq
//   - default operand width and iteration counter width
package muldiv_pkg;

  localparam int WIDTH_DEFAULT = 32;
  localparam int CNT_W_DEFAULT = 6;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PREP = 2'd1,
    S_RUN  = 2'd2,
    S_FIX  = 2'd3
  } state_e;

  // Ops 0..3 occupy the iterative datapath; 4..7 never make it busy.
  function automatic logic is_muldiv(input logic [2:0] op);
    return (op <= OP_DIVU);
  endfunction

  // Within the iterative group, bit 1 selects divide and bit 0 selects unsigned.
  function automatic logic is_div_op(input logic [2:0] op);
    return op[1];
  endfunction

  function automatic logic is_signed_op(input logic [2:0] op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// muldiv_if: EX-stage <-> multiply/divide unit bundle.
//   master (EX stage): drives start, op, a, b, flush, rd_hilo
//                      observes busy, stall, done, hi, lo
//   slave  (muldiv_seq): the reverse
interface muldiv_if #(
  parameter int WIDTH = 32
) ();

  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             flush;
  logic             rd_hilo;
  logic             busy;
  logic             stall;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, flush, rd_hilo,
    input  busy, stall, done, hi, lo
  );

  modport slave (
    input  start, op, a, b, flush, rd_hilo,
    output busy, stall, done, hi, lo
  );

endinterface

// File: rtl/muldiv_step.sv
// muldiv_step: one combinational iteration of the multiply/divide datapath.
//   mode_div : 0 = shift-add multiply step, 1 = restoring divide step
//   acc_hi   : upper accumulator half (partial product / partial remainder)
//   acc_lo   : lower accumulator half (multiplier bits / quotient+dividend bits)
//   operand  : multiplicand (multiply) or divisor (divide)
//   next_hi, next_lo : accumulator pair after this iteration
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic             mode_div,
  input  logic [WIDTH-1:0] acc_hi,
  input  logic [WIDTH-1:0] acc_lo,
  input  logic [WIDTH-1:0] operand,
  output logic [WIDTH-1:0] next_hi,
  output logic [WIDTH-1:0] next_lo
);

  logic [WIDTH:0] mul_sum;
  logic [WIDTH:0] div_shift;
  logic           div_fits;

  // The multiply sum keeps its carry so the right shift brings it back
  // into the top of the accumulator. For divide, the shifted remainder can
  // need WIDTH+1 bits, but once the divisor fits the difference is below
  // the divisor, so a WIDTH-bit subtraction is exact.
  always_comb begin
    mul_sum   = {1'b0, acc_hi};
    if (acc_lo[0]) begin
      mul_sum = {1'b0, acc_hi} + {1'b0, operand};
    end
    div_shift = {acc_hi, acc_lo[WIDTH-1]};
    div_fits  = (div_shift >= {1'b0, operand});

    if (mode_div) begin
      if (div_fits) begin
        next_hi = div_shift[WIDTH-1:0] - operand;
        next_lo = {acc_lo[WIDTH-2:0], 1'b1};
      end else begin
        next_hi = div_shift[WIDTH-1:0];
        next_lo = {acc_lo[WIDTH-2:0], 1'b0};
      end
    end else begin
      next_hi = mul_sum[WIDTH:1];
      next_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// muldiv_seq: multi-cycle HI/LO multiply/divide sequencer.
//   clk, rst : rising-edge clock, synchronous active-high reset
//   bus      : muldiv_if slave port
//     start/op/a/b : issue from EX (MULT, MULTU, DIV, DIVU, MTHI, MTLO)
//     flush        : squash any in-flight operation
//     rd_hilo      : MFHI/MFLO in EX this cycle
//     busy         : an operation is in flight
//     stall        : MFHI/MFLO must wait for a pending result
//     done         : one-cycle pulse after HI/LO take a MULT/DIV result
//     hi, lo       : architectural HI/LO
// Flow: IDLE -> PREP (magnitudes, sign flags) -> RUN (WIDTH steps) -> FIX
// (sign correction and HI/LO write) -> IDLE.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic      clk,
  input  logic      rst,
  muldiv_if.slave   bus
);

  state_e             state;
  state_e             state_next;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   a_reg;
  logic [WIDTH-1:0]   b_reg;
  logic               op_div;
  logic               op_signed;
  logic               neg_q;
  logic               neg_r;
  logic               div_zero;
  logic [WIDTH-1:0]   acc_hi;
  logic [WIDTH-1:0]   acc_lo;
  logic [WIDTH-1:0]   operand;
  logic [WIDTH-1:0]   hi_reg;
  logic [WIDTH-1:0]   lo_reg;
  logic               done_reg;

  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH-1:0]   step_hi;
  logic [WIDTH-1:0]   step_lo;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;
  logic               accept_md;

  assign accept_md = bus.start && !bus.flush && is_muldiv(bus.op);

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .mode_div (op_div),
    .acc_hi   (acc_hi),
    .acc_lo   (acc_lo),
    .operand  (operand),
    .next_hi  (step_hi),
    .next_lo  (step_lo)
  );

  // Operand magnitudes for PREP and sign-corrected results for FIX.
  always_comb begin
    a_mag    = a_reg;
    b_mag    = b_reg;
    if (op_signed && a_reg[WIDTH-1]) begin
      a_mag = WIDTH'(0) - a_reg;
    end
    if (op_signed && b_reg[WIDTH-1]) begin
      b_mag = WIDTH'(0) - b_reg;
    end
    prod_fix = {acc_hi, acc_lo};
    quo_fix  = acc_lo;
    rem_fix  = acc_hi;
    if (neg_q) begin
      prod_fix = (2*WIDTH)'(0) - {acc_hi, acc_lo};
      quo_fix  = WIDTH'(0) - acc_lo;
    end
    if (neg_r) begin
      rem_fix = WIDTH'(0) - acc_hi;
    end
  end

  // Next-state logic; a flush outside IDLE always wins and returns to IDLE.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (accept_md) state_next = S_PREP;
      S_PREP: state_next = (op_div && (b_reg == '0)) ? S_FIX : S_RUN;
      S_RUN:  if (cnt == CNT_W'(WIDTH - 1)) state_next = S_FIX;
      S_FIX:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
    if (bus.flush && (state != S_IDLE)) begin
      state_next = S_IDLE;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Datapath registers. Work done in PREP/RUN under a flush is discarded
  // because FIX is never reached; only FIX touches HI/LO for MULT/DIV.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      op_div    <= 1'b0;
      op_signed <= 1'b0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      div_zero  <= 1'b0;
      acc_hi    <= '0;
      acc_lo    <= '0;
      operand   <= '0;
      hi_reg    <= '0;
      lo_reg    <= '0;
      done_reg  <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept_md) begin
            a_reg     <= bus.a;
            b_reg     <= bus.b;
            op_div    <= is_div_op(bus.op);
            op_signed <= is_signed_op(bus.op);
          end else if (bus.start && !bus.flush && (bus.op == OP_MTHI)) begin
            hi_reg <= bus.a;
          end else if (bus.start && !bus.flush && (bus.op == OP_MTLO)) begin
            lo_reg <= bus.a;
          end
        end
        S_PREP: begin
          neg_q    <= op_signed && (a_reg[WIDTH-1] ^ b_reg[WIDTH-1]);
          neg_r    <= op_signed && a_reg[WIDTH-1];
          div_zero <= op_div && (b_reg == '0);
          cnt      <= '0;
          acc_hi   <= '0;
          // Multiply: multiplier in the low half, multiplicand added on top.
          // Divide: dividend in the low half, shifted into the remainder.
          acc_lo   <= op_div ? a_mag : b_mag;
          operand  <= op_div ? b_mag : a_mag;
        end
        S_RUN: begin
          acc_hi <= step_hi;
          acc_lo <= step_lo;
          cnt    <= cnt + CNT_W'(1);
        end
        S_FIX: begin
          if (!bus.flush) begin
            done_reg <= 1'b1;
            if (div_zero) begin
              hi_reg <= a_reg;
              lo_reg <= '1;
            end else if (op_div) begin
              hi_reg <= rem_fix;
              lo_reg <= quo_fix;
            end else begin
              hi_reg <= prod_fix[2*WIDTH-1:WIDTH];
              lo_reg <= prod_fix[WIDTH-1:0];
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy  = (state != S_IDLE);
  assign bus.stall = bus.rd_hilo && ((state != S_IDLE) || (bus.start && is_muldiv(bus.op)));
  assign bus.done  = done_reg;
  assign bus.hi    = hi_reg;
  assign bus.lo    = lo_reg;

endmodule
